// File: rtl/sys_pkg.sv
// Shared definitions for the systolic multiplier: operand/sum widths,
// default PE row length and the result-drain state encoding.
package sys_pkg;

  localparam int SUM_W  = 10;
  localparam int OP_W   = 4;
  localparam int NUM_PE = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/mac_result_drain.sv
// Result drain for a MAC PE row: snapshots all PE sums on a capture pulse,
// clears the row for the next accumulation and streams the captured sums
// out one per beat over valid/ready.
module mac_result_drain #(
  parameter int NUM_PE = sys_pkg::NUM_PE,
  parameter int SUM_W  = sys_pkg::SUM_W,
  parameter int IDX_W  = $clog2(NUM_PE)
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [NUM_PE*SUM_W-1:0] sum_in,
  input  logic                    cap,
  output logic                    cap_ready,
  output logic                    pe_clr,
  output logic [SUM_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    ovr_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  sys_pkg::drain_state_t state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [SUM_W-1:0]      sbuf [NUM_PE];
  logic                  accept;
  logic                  drop;
  logic                  xfer;

  // A capture slot opens in IDLE or on the edge where the last beat leaves.
  always_comb begin
    cap_ready = (state == sys_pkg::IDLE) ||
                ((state == sys_pkg::SEND) && out_last && out_ready);
    accept    = cap && cap_ready;
    drop      = cap && !cap_ready;
    xfer      = out_valid && out_ready;
    idx_nxt   = idx + 1'b1;
  end

  // Shadow buffer: reloaded only by an accepted capture, held otherwise.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int k = 0; k < NUM_PE; k++) sbuf[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_PE; k++) sbuf[k] <= sum_in[k*SUM_W +: SUM_W];
    end
  end

  // Drain FSM and registered beat outputs; data/idx/last only move on a
  // transfer or a capture, so they hold steady under backpressure.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= sys_pkg::IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // First beat comes straight from sum_in since the buffer loads now.
      state     <= sys_pkg::SEND;
      idx       <= '0;
      out_data  <= sum_in[SUM_W-1:0];
      out_last  <= 1'b0;
      out_valid <= 1'b1;
      busy      <= 1'b1;
    end else if (xfer) begin
      if (out_last) begin
        state     <= sys_pkg::IDLE;
        idx       <= '0;
        out_last  <= 1'b0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        idx      <= idx_nxt;
        out_data <= sbuf[idx_nxt];
        out_last <= (idx_nxt == LAST_IDX);
      end
    end
  end

  // One-cycle PE row clear following each accepted capture.
  always_ff @(posedge clk or negedge res) begin
    if (!res) pe_clr <= 1'b0;
    else      pe_clr <= accept;
  end

  // Sticky overrun flag; a dropped capture beats a simultaneous clear.
  always_ff @(posedge clk or negedge res) begin
    if (!res)         overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

  assign out_idx = idx;

endmodule
